multicycle_ctrl_fsm: RTL and testbench

- Sequencing controller for the multi-cycle RV32I core. It replaces the single-cycle control unit's per-instruction decode with a per-cycle state machine.
- It drives the shared ALU, unified memory port, IR/ALUOut/PC/register-file write enables and datapath muxes across IF/ID/EX/MEM/WB.
- It owns the memory ready handshake, a memory-stall watchdog, and the ecall/illegal-instruction halt.

---
 rtl/multicycle_ctrl_fsm.sv | 227 ++++++++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_fsm.sv
// rtl/multicycle_ctrl_fsm.sv - per-cycle sequencing controller for the multi-cycle RV32I core
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   opcode              IR[6:0], valid from ID onward
//   alu_bcond           branch-compare result, valid in EX
//   ecall_halt_req      ecall requests a halt, valid in ID
//   mem_ready           memory completes the current access this cycle
//   ir_write .. mem_to_reg  datapath write enables and mux selects
//   state               current FSM state (IF=0 ID=1 EX=2 MEM=3 WB=4 BR=5 HALT=6)
//   mem_error           sticky, set when the memory-stall watchdog fires
//   is_halted           high while in HALT
module multicycle_ctrl_fsm #(
  parameter int MEM_WAIT_MAX = 15,
  parameter int WAIT_CNT_W   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       alu_bcond,
  input  logic       ecall_halt_req,
  input  logic       mem_ready,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op_sel,
  output logic       alu_out_write,
  output logic       pc_write,
  output logic       pc_source,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic [2:0] state,
  output logic       mem_error,
  output logic       is_halted
);

  localparam logic [2:0] S_IF   = 3'd0;
  localparam logic [2:0] S_ID   = 3'd1;
  localparam logic [2:0] S_EX   = 3'd2;
  localparam logic [2:0] S_MEM  = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;
  localparam logic [2:0] S_BR   = 3'd5;
  localparam logic [2:0] S_HALT = 3'd6;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;

  logic [2:0]            state_q, state_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic                  mem_error_q;
  logic                  wd_hit;
  logic                  wd_fire;
  logic                  is_load;
  logic                  is_store;

  assign is_load  = (opcode == OP_LOAD);
  assign is_store = (opcode == OP_STORE);

  // Stall limit reached; only meaningful in IF/MEM while mem_ready is low.
  assign wd_hit = (MEM_WAIT_MAX > 0) && (wait_cnt_q == WAIT_CNT_W'(MEM_WAIT_MAX));

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IF;
      wait_cnt_q  <= '0;
      mem_error_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (wd_fire) begin
        mem_error_q <= 1'b1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    wd_fire = 1'b0;
    case (state_q)
      S_IF: begin
        if (mem_ready) begin
          state_d = S_ID;
        end else if (wd_hit) begin
          state_d = S_HALT;
          wd_fire = 1'b1;
        end
      end
      S_ID: begin
        case (opcode)
          OP_ECALL:                         state_d = ecall_halt_req ? S_HALT : S_IF;
          OP_R, OP_I, OP_LOAD, OP_STORE,
          OP_BRANCH, OP_JAL, OP_JALR:       state_d = S_EX;
          default:                          state_d = S_HALT;
        endcase
      end
      S_EX: begin
        case (opcode)
          OP_R, OP_I, OP_JAL, OP_JALR: state_d = S_WB;
          OP_LOAD, OP_STORE:           state_d = S_MEM;
          OP_BRANCH:                   state_d = alu_bcond ? S_BR : S_IF;
          default:                     state_d = S_HALT;
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          state_d = is_load ? S_WB : S_IF;
        end else if (wd_hit) begin
          state_d = S_HALT;
          wd_fire = 1'b1;
        end
      end
      S_WB:    state_d = S_IF;
      S_BR:    state_d = S_IF;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IF;
    endcase

    // Stall counter only runs while a memory access waits in the same state.
    if (state_d != state_q) begin
      wait_cnt_d = '0;
    end else if ((state_q == S_IF || state_q == S_MEM) && !mem_ready) begin
      wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
    end else begin
      wait_cnt_d = '0;
    end
  end

  // Output decode
  always_comb begin
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    alu_op_sel    = 2'd0;
    alu_out_write = 1'b0;
    pc_write      = 1'b0;
    pc_source     = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    if (!reset) begin
      case (state_q)
        S_IF: begin
          mem_read = 1'b1;
          ir_write = mem_ready;
        end
        S_ID: begin
          // PC+4 is computed here so every path below can reuse it.
          alu_src_b     = 2'd2;
          alu_out_write = 1'b1;
          if (opcode == OP_ECALL && !ecall_halt_req) begin
            pc_write = 1'b1;
          end
        end
        S_EX: begin
          case (opcode)
            OP_R: begin
              alu_src_a = 1'b1; alu_op_sel = 2'd1; alu_out_write = 1'b1;
            end
            OP_I: begin
              alu_src_a = 1'b1; alu_src_b = 2'd1; alu_op_sel = 2'd1; alu_out_write = 1'b1;
            end
            OP_LOAD, OP_STORE: begin
              alu_src_a = 1'b1; alu_src_b = 2'd1; alu_out_write = 1'b1;
            end
            OP_BRANCH: begin
              alu_src_a  = 1'b1;
              alu_op_sel = 2'd2;
              // Not taken: ALUOut still holds PC+4 from ID.
              if (!alu_bcond) begin
                pc_write  = 1'b1;
                pc_source = 1'b1;
              end
            end
            // Jump target goes straight to PC; ALUOut keeps PC+4 for the link write.
            OP_JAL: begin
              alu_src_b = 2'd1; pc_write = 1'b1;
            end
            OP_JALR: begin
              alu_src_a = 1'b1; alu_src_b = 2'd1; pc_write = 1'b1;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          i_or_d    = 1'b1;
          mem_read  = is_load;
          mem_write = is_store;
          if (is_store && mem_ready) begin
            alu_src_b = 2'd2;
            pc_write  = 1'b1;
          end
        end
        S_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = is_load;
          if (opcode != OP_JAL && opcode != OP_JALR) begin
            alu_src_b = 2'd2;
            pc_write  = 1'b1;
          end
        end
        S_BR: begin
          alu_src_b = 2'd1;
          pc_write  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state     = state_q;
  assign mem_error = mem_error_q;
  assign is_halted = (state_q == S_HALT);

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb/tb_multicycle_ctrl_fsm.sv - directed self-checking bench for multicycle_ctrl_fsm
module tb_multicycle_ctrl_fsm;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;

  // Control word: {ir,mr,mw,iod}_{a}_{b}_{op}_{aow,pw,ps,rw,m2r}_{halted}
  localparam logic [14:0] C_IFR   = 15'b1100_0_00_00_00000_0;
  localparam logic [14:0] C_IFN   = 15'b0100_0_00_00_00000_0;
  localparam logic [14:0] C_ID    = 15'b0000_0_10_00_10000_0;
  localparam logic [14:0] C_IDEC  = 15'b0000_0_10_00_11000_0;
  localparam logic [14:0] C_EXR   = 15'b0000_1_00_01_10000_0;
  localparam logic [14:0] C_EXLS  = 15'b0000_1_01_00_10000_0;
  localparam logic [14:0] C_EXB0  = 15'b0000_1_00_10_01100_0;
  localparam logic [14:0] C_EXB1  = 15'b0000_1_00_10_00000_0;
  localparam logic [14:0] C_EXJAL = 15'b0000_0_01_00_01000_0;
  localparam logic [14:0] C_BR    = 15'b0000_0_01_00_01000_0;
  localparam logic [14:0] C_MEMLD = 15'b0101_0_00_00_00000_0;
  localparam logic [14:0] C_MEMSN = 15'b0011_0_00_00_00000_0;
  localparam logic [14:0] C_MEMSR = 15'b0011_0_10_00_01000_0;
  localparam logic [14:0] C_WBR   = 15'b0000_0_10_00_01010_0;
  localparam logic [14:0] C_WBLD  = 15'b0000_0_10_00_01011_0;
  localparam logic [14:0] C_WBJ   = 15'b0000_0_00_00_00010_0;
  localparam logic [14:0] C_HALT  = 15'b0000_0_00_00_00000_1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic       alu_bcond = 1'b0;
  logic       ecall_halt_req = 1'b0;
  logic       mem_ready = 1'b0;
  logic       ir_write, mem_read, mem_write, i_or_d, alu_src_a;
  logic [1:0] alu_src_b, alu_op_sel;
  logic       alu_out_write, pc_write, pc_source, reg_write, mem_to_reg;
  logic [2:0] state;
  logic       mem_error, is_halted;
  logic [14:0] ctl;

  int checks = 0;
  int errors = 0;

  assign ctl = {ir_write, mem_read, mem_write, i_or_d, alu_src_a, alu_src_b, alu_op_sel,
                alu_out_write, pc_write, pc_source, reg_write, mem_to_reg, is_halted};

  always #5 clk = ~clk;

  multicycle_ctrl_fsm #(.MEM_WAIT_MAX(15), .WAIT_CNT_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .alu_bcond(alu_bcond),
    .ecall_halt_req(ecall_halt_req), .mem_ready(mem_ready),
    .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op_sel(alu_op_sel),
    .alu_out_write(alu_out_write), .pc_write(pc_write), .pc_source(pc_source),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .state(state),
    .mem_error(mem_error), .is_halted(is_halted)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench just after an edge with the DUT in its first IF cycle.
  task automatic do_reset();
    reset = 1'b1;
    mem_ready = 1'b0;
    alu_bcond = 1'b0;
    ecall_halt_req = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    opcode = OP_R;
    mem_ready = 1'b1;
    tick();
    #1;
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
    checks++; if (ctl !== 15'd0) begin errors++; $display("FAIL reset_ctl got %b exp %b", ctl, 15'd0); end
    checks++; if (mem_error !== 1'b0) begin errors++; $display("FAIL reset_mem_error got %b exp 0", mem_error); end
    reset = 1'b0;
    #1;
    checks++; if (ctl !== C_IFR) begin errors++; $display("FAIL reset_release_ctl got %b exp %b", ctl, C_IFR); end
  endtask

  task automatic test_add();
    logic [2:0]  st [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
    logic        rdy[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [14:0] c  [5] = '{C_IFR, C_ID, C_EXR, C_WBR, C_IFN};
    do_reset();
    opcode = OP_R;
    for (int i = 0; i < 5; i++) begin
      mem_ready = rdy[i]; #1;
      checks++; if (state !== st[i]) begin errors++; $display("FAIL add_state cyc %0d got %0d exp %0d", i, state, st[i]); end
      checks++; if (ctl !== c[i]) begin errors++; $display("FAIL add_ctl cyc %0d got %b exp %b", i, ctl, c[i]); end
      tick();
    end
  endtask

  task automatic test_load_wait();
    logic [2:0]  st [9] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4, 3'd0};
    logic        rdy[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [14:0] c  [9] = '{C_IFR, C_ID, C_EXLS, C_MEMLD, C_MEMLD, C_MEMLD, C_MEMLD, C_WBLD, C_IFN};
    do_reset();
    opcode = OP_LOAD;
    for (int i = 0; i < 9; i++) begin
      mem_ready = rdy[i]; #1;
      checks++; if (state !== st[i]) begin errors++; $display("FAIL lw_state cyc %0d got %0d exp %0d", i, state, st[i]); end
      checks++; if (ctl !== c[i]) begin errors++; $display("FAIL lw_ctl cyc %0d got %b exp %b", i, ctl, c[i]); end
      tick();
    end
  endtask

  task automatic test_store();
    logic [2:0]  st [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd0};
    logic        rdy[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [14:0] c  [6] = '{C_IFR, C_ID, C_EXLS, C_MEMSN, C_MEMSR, C_IFN};
    do_reset();
    opcode = OP_STORE;
    for (int i = 0; i < 6; i++) begin
      mem_ready = rdy[i]; #1;
      checks++; if (state !== st[i]) begin errors++; $display("FAIL sw_state cyc %0d got %0d exp %0d", i, state, st[i]); end
      checks++; if (ctl !== c[i]) begin errors++; $display("FAIL sw_ctl cyc %0d got %b exp %b", i, ctl, c[i]); end
      tick();
    end
  endtask

  task automatic test_branch();
    logic [2:0]  st_n[4] = '{3'd0, 3'd1, 3'd2, 3'd0};
    logic [14:0] c_n [4] = '{C_IFR, C_ID, C_EXB0, C_IFN};
    logic [2:0]  st_t[5] = '{3'd0, 3'd1, 3'd2, 3'd5, 3'd0};
    logic [14:0] c_t [5] = '{C_IFR, C_ID, C_EXB1, C_BR, C_IFN};
    do_reset();
    opcode = OP_BRANCH;
    alu_bcond = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 0); #1;
      checks++; if (state !== st_n[i]) begin errors++; $display("FAIL beq_nt_state cyc %0d got %0d exp %0d", i, state, st_n[i]); end
      checks++; if (ctl !== c_n[i]) begin errors++; $display("FAIL beq_nt_ctl cyc %0d got %b exp %b", i, ctl, c_n[i]); end
      tick();
    end
    do_reset();
    alu_bcond = 1'b1;
    for (int i = 0; i < 5; i++) begin
      mem_ready = (i == 0); #1;
      checks++; if (state !== st_t[i]) begin errors++; $display("FAIL beq_t_state cyc %0d got %0d exp %0d", i, state, st_t[i]); end
      checks++; if (ctl !== c_t[i]) begin errors++; $display("FAIL beq_t_ctl cyc %0d got %b exp %b", i, ctl, c_t[i]); end
      tick();
    end
  endtask

  task automatic test_jal();
    logic [2:0]  st [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
    logic [14:0] c  [5] = '{C_IFR, C_ID, C_EXJAL, C_WBJ, C_IFN};
    do_reset();
    opcode = OP_JAL;
    for (int i = 0; i < 5; i++) begin
      mem_ready = (i == 0); #1;
      checks++; if (state !== st[i]) begin errors++; $display("FAIL jal_state cyc %0d got %0d exp %0d", i, state, st[i]); end
      checks++; if (ctl !== c[i]) begin errors++; $display("FAIL jal_ctl cyc %0d got %b exp %b", i, ctl, c[i]); end
      tick();
    end
  endtask

  task automatic test_ecall();
    do_reset();
    opcode = OP_ECALL;
    ecall_halt_req = 1'b0;
    mem_ready = 1'b1; tick();
    mem_ready = 1'b0; #1;
    checks++; if (ctl !== C_IDEC) begin errors++; $display("FAIL ecall_id_ctl got %b exp %b", ctl, C_IDEC); end
    tick();
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL ecall_ret_state got %0d exp 0", state); end
    do_reset();
    ecall_halt_req = 1'b1;
    mem_ready = 1'b1; tick();
    #1;
    checks++; if (ctl !== C_ID) begin errors++; $display("FAIL ecall_halt_id_ctl got %b exp %b", ctl, C_ID); end
    tick();
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0]; #1;
      checks++; if (state !== 3'd6) begin errors++; $display("FAIL ecall_halt_state cyc %0d got %0d exp 6", i, state); end
      checks++; if (ctl !== C_HALT) begin errors++; $display("FAIL ecall_halt_ctl cyc %0d got %b exp %b", i, ctl, C_HALT); end
      tick();
    end
    checks++; if (mem_error !== 1'b0) begin errors++; $display("FAIL ecall_mem_error got %b exp 0", mem_error); end
  endtask

  task automatic test_illegal();
    do_reset();
    opcode = 7'b0000000;
    mem_ready = 1'b1;
    tick(); tick();
    #1;
    checks++; if (state !== 3'd6) begin errors++; $display("FAIL illegal_state got %0d exp 6", state); end
    checks++; if (mem_error !== 1'b0) begin errors++; $display("FAIL illegal_mem_error got %b exp 0", mem_error); end
  endtask

  task automatic test_watchdog();
    do_reset();
    opcode = OP_R;
    for (int i = 0; i < 16; i++) begin
      mem_ready = 1'b0; #1;
      checks++; if (state !== 3'd0) begin errors++; $display("FAIL wd_if_state cyc %0d got %0d exp 0", i, state); end
      tick();
    end
    #1;
    checks++; if (state !== 3'd6) begin errors++; $display("FAIL wd_halt_state got %0d exp 6", state); end
    checks++; if (mem_error !== 1'b1) begin errors++; $display("FAIL wd_mem_error got %b exp 1", mem_error); end
    checks++; if (ctl !== C_HALT) begin errors++; $display("FAIL wd_halt_ctl got %b exp %b", ctl, C_HALT); end
    // Ready on the limit cycle is a success.
    do_reset();
    #1;
    checks++; if (mem_error !== 1'b0) begin errors++; $display("FAIL wd_reset_clear got %b exp 0", mem_error); end
    for (int i = 0; i < 15; i++) begin
      mem_ready = 1'b0;
      tick();
    end
    mem_ready = 1'b1; #1;
    checks++; if (ctl !== C_IFR) begin errors++; $display("FAIL wd_limit_ctl got %b exp %b", ctl, C_IFR); end
    tick();
    mem_ready = 1'b0; #1;
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL wd_limit_state got %0d exp 1", state); end
    checks++; if (mem_error !== 1'b0) begin errors++; $display("FAIL wd_limit_mem_error got %b exp 0", mem_error); end
  endtask

  task automatic test_reset_mid_mem();
    do_reset();
    opcode = OP_LOAD;
    mem_ready = 1'b1; tick();
    mem_ready = 1'b0; tick(); tick();
    #1;
    checks++; if (state !== 3'd3) begin errors++; $display("FAIL rst_mem_state got %0d exp 3", state); end
    reset = 1'b1; #1;
    checks++; if (ctl !== 15'd0) begin errors++; $display("FAIL rst_mem_forced got %b exp %b", ctl, 15'd0); end
    tick();
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL rst_mem_after_state got %0d exp 0", state); end
    checks++; if (mem_error !== 1'b0) begin errors++; $display("FAIL rst_mem_error got %b exp 0", mem_error); end
    reset = 1'b0; mem_ready = 1'b1; #1;
    checks++; if (ctl !== C_IFR) begin errors++; $display("FAIL rst_mem_refetch got %b exp %b", ctl, C_IFR); end
    tick();
  endtask

  initial begin
    test_reset();
    test_add();
    test_load_wait();
    test_store();
    test_branch();
    test_jal();
    test_ecall();
    test_illegal();
    test_watchdog();
    test_reset_mid_mem();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
